rpn_seq_ctrl: RTL and testbench

RPN_SEQ_CTRL -- requirements
Module: rpn_seq_ctrl

---
 rtl/rpn_seq_ctrl_if.sv | 34 +++
 rtl/rpn_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_rpn_seq_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/rpn_seq_ctrl_if.sv
// Command, stack-memory and ALU signal bundle for the RPN sequencer.
// The slave side is the controller; the master side is the environment (issuer, memory, ALU).
interface rpn_seq_ctrl_if #(
  parameter int AW = 4
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [7:0]    cmd_data;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic [1:0]    alu_op;
  logic [7:0]    alu_result;
  logic [AW:0]   sp;
  logic          done;
  logic          err;
  logic [1:0]    err_code;

  modport master (
    output cmd_valid, cmd_op, cmd_data, mem_rdata, alu_result,
    input  cmd_ready, mem_addr, mem_we, mem_wdata, alu_a, alu_b, alu_op,
           sp, done, err, err_code
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, mem_rdata, alu_result,
    output cmd_ready, mem_addr, mem_we, mem_wdata, alu_a, alu_b, alu_op,
           sp, done, err, err_code
  );
endinterface

// File: rtl/rpn_seq_ctrl.sv
// RPN stack sequencer: one command at a time, operands read from an external registered-read
// stack memory, result written back through one WRITE cycle; done/err pulse for one cycle.
module rpn_seq_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  rpn_seq_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD1, RD2, RD3, WRITE, DONE, ERR} state_t;

  localparam logic [2:0]  OP_NOP   = 3'b000;
  localparam logic [2:0]  OP_PUSH  = 3'b001;
  localparam logic [2:0]  OP_POP   = 3'b010;
  localparam logic [2:0]  OP_DUP   = 3'b011;
  localparam logic [1:0]  CODE_UND = 2'b01;
  localparam logic [1:0]  CODE_OVF = 2'b10;
  localparam logic [AW:0] SP_FULL  = (AW+1)'(DEPTH);

  state_t        state, state_nxt;
  logic [2:0]    op_q;
  logic [7:0]    data_q;
  logic [7:0]    reg_a, reg_b;
  logic [AW:0]   sp_q;
  logic [1:0]    code_q, code_nxt;
  logic          accept;
  logic          grows;
  logic [AW-1:0] sp_lo, sp_m1, sp_m2;

  assign accept = bus.cmd_valid && (state == IDLE);
  assign grows  = (op_q == OP_PUSH) || (op_q == OP_DUP);
  // DEPTH is a power of two, so modulo-AW address arithmetic maps sp=DEPTH to DEPTH-1 correctly.
  assign sp_lo  = sp_q[AW-1:0];
  assign sp_m1  = sp_lo - AW'(1);
  assign sp_m2  = sp_lo - AW'(2);

  always_comb begin
    state_nxt = state;
    code_nxt  = code_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (bus.cmd_op)
            OP_NOP: state_nxt = DONE;
            OP_POP: begin
              if (sp_q >= 1) state_nxt = DONE;
              else begin state_nxt = ERR; code_nxt = CODE_UND; end
            end
            OP_PUSH: begin
              if (sp_q < SP_FULL) state_nxt = WRITE;
              else begin state_nxt = ERR; code_nxt = CODE_OVF; end
            end
            OP_DUP: begin
              if (sp_q == 0) begin state_nxt = ERR; code_nxt = CODE_UND; end
              else if (sp_q == SP_FULL) begin state_nxt = ERR; code_nxt = CODE_OVF; end
              else state_nxt = RD1;
            end
            default: begin
              if (sp_q >= 2) state_nxt = RD1;
              else begin state_nxt = ERR; code_nxt = CODE_UND; end
            end
          endcase
        end
      end
      RD1:     state_nxt = RD2;
      RD2:     state_nxt = (op_q == OP_DUP) ? WRITE : RD3;
      RD3:     state_nxt = WRITE;
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = 8'h00;
    unique case (state)
      RD1: bus.mem_addr = sp_m1;
      RD2: if (op_q != OP_DUP) bus.mem_addr = sp_m2;
      WRITE: begin
        bus.mem_addr  = grows ? sp_lo : sp_m2;
        bus.mem_wdata = (op_q == OP_PUSH) ? data_q :
                        (op_q == OP_DUP)  ? reg_b  : bus.alu_result;
      end
      default: ;
    endcase
  end

  // Gating with reset keeps an aborted command from writing or signalling in the reset cycle.
  assign bus.mem_we    = (state == WRITE) && !reset;
  assign bus.done      = (state == DONE) && !reset;
  assign bus.err       = (state == ERR) && !reset;
  assign bus.err_code  = bus.err ? code_q : 2'b00;
  assign bus.cmd_ready = (state == IDLE);
  assign bus.alu_a     = reg_a;
  assign bus.alu_b     = reg_b;
  assign bus.alu_op    = op_q[1:0];
  assign bus.sp        = sp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sp_q   <= '0;
      reg_a  <= 8'h00;
      reg_b  <= 8'h00;
      op_q   <= OP_NOP;
      data_q <= 8'h00;
      code_q <= 2'b00;
    end else begin
      state  <= state_nxt;
      code_q <= code_nxt;
      if (accept) begin
        op_q   <= bus.cmd_op;
        data_q <= bus.cmd_data;
      end
      if (accept && (bus.cmd_op == OP_POP) && (sp_q != 0)) sp_q <= sp_q - 1'b1;
      if (state == RD2) reg_b <= bus.mem_rdata;
      if (state == RD3) reg_a <= bus.mem_rdata;
      if (state == WRITE) sp_q <= grows ? sp_q + 1'b1 : sp_q - 1'b1;
    end
  end
endmodule

// File: tb/tb_rpn_seq_ctrl.sv
// Bench for rpn_seq_ctrl: behavioural stack memory and ALU around the DUT, a vector table of
// commands with hand-computed results, plus sequences for overflow, reset abort and held valid.
module tb_rpn_seq_ctrl;
  localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, POP = 3'b010, DUP = 3'b011;
  localparam logic [2:0] ADD = 3'b100, SUB = 3'b101, AND = 3'b110, OR = 3'b111;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   accepts;

  rpn_seq_ctrl_if #(.AW(4)) bus ();

  rpn_seq_ctrl #(.DEPTH(16), .AW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  always_comb begin
    case (bus.alu_op)
      2'b00:   bus.alu_result = bus.alu_a + bus.alu_b;
      2'b01:   bus.alu_result = bus.alu_a - bus.alu_b;
      2'b10:   bus.alu_result = bus.alu_a & bus.alu_b;
      default: bus.alu_result = bus.alu_a | bus.alu_b;
    endcase
  end

  always @(posedge clk) if (!reset && bus.cmd_valid && bus.cmd_ready) accepts++;

  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
    int         lat;
    logic [1:0] code;
    int         sp;
    int         nw;
    logic [3:0] waddr;
    logic [7:0] wdata;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_cmd(input string nm, input logic [2:0] op, input logic [7:0] data,
                         input int exp_lat, input logic [1:0] exp_code, input int exp_sp,
                         input int exp_nw, input logic [3:0] exp_waddr, input logic [7:0] exp_wdata);
    int lat, nw, wcyc, sp_at;
    logic [3:0] wa;
    logic [7:0] wd;
    logic [3:0] res;
    lat = 0; nw = 0; wcyc = 0; sp_at = -1; wa = '0; wd = '0; res = '0;
    @(negedge clk);
    chk({nm, "_ready"}, int'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    for (int n = 1; n <= 12 && lat == 0; n++) begin
      @(negedge clk);
      if (bus.mem_we) begin nw++; wa = bus.mem_addr; wd = bus.mem_wdata; wcyc = n; end
      if (bus.done || bus.err) begin
        lat   = n;
        res   = {bus.done, bus.err, bus.err_code};
        sp_at = int'(bus.sp);
      end
    end
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_done_err_code"}, int'(res), int'({exp_code == 2'b00, exp_code != 2'b00, exp_code}));
    chk({nm, "_sp"}, sp_at, exp_sp);
    chk({nm, "_writes"}, nw, exp_nw);
    if (exp_nw == 1) begin
      chk({nm, "_waddr"}, int'(wa), int'(exp_waddr));
      chk({nm, "_wdata"}, int'(wd), int'(exp_wdata));
      chk({nm, "_wcycle"}, wcyc, exp_lat - 1);
    end
  endtask

  initial begin
    int bad, acc0;
    checks = 0; failures = 0; accepts = 0;
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = NOP;
    bus.cmd_data  = 8'h00;

    vecs[0]  = '{PUSH, 8'h07, 2, 2'b00, 1, 1, 4'd0, 8'h07};
    vecs[1]  = '{PUSH, 8'h05, 2, 2'b00, 2, 1, 4'd1, 8'h05};
    vecs[2]  = '{SUB,  8'h00, 5, 2'b00, 1, 1, 4'd0, 8'h02};
    vecs[3]  = '{POP,  8'h00, 1, 2'b00, 0, 0, 4'd0, 8'h00};
    vecs[4]  = '{POP,  8'h00, 1, 2'b01, 0, 0, 4'd0, 8'h00};
    vecs[5]  = '{DUP,  8'h00, 1, 2'b01, 0, 0, 4'd0, 8'h00};
    vecs[6]  = '{ADD,  8'h00, 1, 2'b01, 0, 0, 4'd0, 8'h00};
    vecs[7]  = '{PUSH, 8'hFF, 2, 2'b00, 1, 1, 4'd0, 8'hFF};
    vecs[8]  = '{ADD,  8'h00, 1, 2'b01, 1, 0, 4'd0, 8'h00};
    vecs[9]  = '{PUSH, 8'h02, 2, 2'b00, 2, 1, 4'd1, 8'h02};
    vecs[10] = '{ADD,  8'h00, 5, 2'b00, 1, 1, 4'd0, 8'h01};
    vecs[11] = '{DUP,  8'h00, 4, 2'b00, 2, 1, 4'd1, 8'h01};
    vecs[12] = '{PUSH, 8'h3C, 2, 2'b00, 3, 1, 4'd2, 8'h3C};
    vecs[13] = '{AND,  8'h00, 5, 2'b00, 2, 1, 4'd1, 8'h00};
    vecs[14] = '{PUSH, 8'h82, 2, 2'b00, 3, 1, 4'd2, 8'h82};
    vecs[15] = '{OR,   8'h00, 5, 2'b00, 2, 1, 4'd1, 8'h82};
    vecs[16] = '{SUB,  8'h00, 5, 2'b00, 1, 1, 4'd0, 8'h7F};
    vecs[17] = '{NOP,  8'h00, 1, 2'b00, 1, 0, 4'd0, 8'h00};
    vecs[18] = '{POP,  8'h00, 1, 2'b00, 0, 0, 4'd0, 8'h00};

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", int'(bus.cmd_ready), 1);
    chk("rst_sp", int'(bus.sp), 0);
    chk("rst_flags", int'({bus.done, bus.err, bus.err_code, bus.mem_we}), 0);
    chk("rst_addr", int'(bus.mem_addr), 0);
    chk("rst_alu", int'({bus.alu_a, bus.alu_b}), 0);

    for (int i = 0; i < 19; i++)
      run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].lat, vecs[i].code,
              vecs[i].sp, vecs[i].nw, vecs[i].waddr, vecs[i].wdata);

    // Fill to DEPTH, then both growing commands must report overflow without writing.
    do_reset();
    for (int i = 0; i < 16; i++)
      run_cmd($sformatf("fill%0d", i), PUSH, 8'(8'h10 + i), 2, 2'b00, i + 1, 1, 4'(i), 8'(8'h10 + i));
    run_cmd("push_full", PUSH, 8'hAA, 1, 2'b10, 16, 0, 4'd0, 8'h00);
    run_cmd("dup_full", DUP, 8'h00, 1, 2'b10, 16, 0, 4'd0, 8'h00);
    run_cmd("pop_full", POP, 8'h00, 1, 2'b00, 15, 0, 4'd0, 8'h00);
    run_cmd("add_deep", ADD, 8'h00, 5, 2'b00, 14, 1, 4'd13, 8'h3B);

    // Reset during RD3 of an ADD aborts it.
    do_reset();
    run_cmd("ab_push1", PUSH, 8'h01, 2, 2'b00, 1, 1, 4'd0, 8'h01);
    run_cmd("ab_push2", PUSH, 8'h02, 2, 2'b00, 2, 1, 4'd1, 8'h02);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = ADD;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.mem_we || bus.done || bus.err) bad++;
    end
    reset = 1'b1;
    @(negedge clk);
    if (bus.mem_we || bus.done || bus.err) bad++;
    reset = 1'b0;
    chk("abort_ready", int'(bus.cmd_ready), 1);
    chk("abort_sp", int'(bus.sp), 0);
    repeat (6) begin
      @(negedge clk);
      if (bus.mem_we || bus.done || bus.err) bad++;
    end
    chk("abort_quiet", bad, 0);

    // Reset wins over a simultaneous accept.
    acc0 = accepts;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = PUSH;
    bus.cmd_data  = 8'h66;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.cmd_valid = 1'b0;
    chk("rstprio_ready", int'(bus.cmd_ready), 1);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.mem_we || bus.done || bus.err) bad++;
    end
    chk("rstprio_quiet", bad, 0);
    chk("rstprio_accepts", accepts - acc0, 0);
    chk("rstprio_sp", int'(bus.sp), 0);

    // cmd_valid held through a busy period is accepted once.
    acc0 = accepts;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = PUSH;
    bus.cmd_data  = 8'h44;
    bad = 1;
    for (int n = 0; n < 12 && bad != 0; n++) begin
      @(negedge clk);
      if (bus.done) bad = 0;
    end
    bus.cmd_valid = 1'b0;
    chk("held_done_seen", bad, 0);
    repeat (3) @(negedge clk);
    chk("held_accepts", accepts - acc0, 1);
    chk("held_sp", int'(bus.sp), 1);
    chk("held_mem", int'(mem[0]), 8'h44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
